// File: rtl/gf2_linear_map_pipe.sv
// gf2_linear_map_pipe: LANES-wide GF(2) 8x8 linear map (built-in inverse map or programmed matrix)
// behind a PIPE-stage valid/ready pipeline. Define AFFINE_CONST_EN to load and commit an affine constant.
module gf2_linear_map_pipe #(
  parameter int LANES = 4,
  parameter int PIPE  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  input  logic               cfg_start,
  input  logic               cfg_valid,
  input  logic [7:0]         cfg_row,
  output logic               cfg_ready,
  output logic               cfg_busy
);
  localparam int W = 8 * LANES;

`ifdef AFFINE_CONST_EN
  localparam logic [3:0] LAST_WORD = 4'd8;
  localparam logic [3:0] ROW_OFS   = 4'd1;
`else
  localparam logic [3:0] LAST_WORD = 4'd7;
  localparam logic [3:0] ROW_OFS   = 4'd0;
`endif

  // state  | meaning
  // IDLE   | active matrix in use, waiting for cfg_start
  // LOAD   | accepting words into the shadow matrix
  // DRAIN  | mode-1 input blocked until no mode-1 word is in flight
  // COMMIT | one cycle, shadow copied into active
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, COMMIT} cfg_state_t;

  cfg_state_t state, state_nxt;

  logic [3:0]      wcnt;
  logic [7:0]      act_row [8];
  logic [7:0]      shd_row [8];
  logic [7:0]      act_const;
  logic            row_we;

  logic [PIPE-1:0] st_valid;
  logic [PIPE-1:0] st_mode;
  logic [W-1:0]    st_data [PIPE];

  logic            stall;
  logic            accept;
  logic            mode1_busy;
  logic            mode1_block;
  logic [W-1:0]    map_data;
  logic [7:0]      lane_in;
  logic [7:0]      lane_out;

  function automatic logic [7:0] inv_map(input logic [7:0] i);
    logic [7:0] o;
    o[7] = i[2];
    o[6] = i[5] ^ i[1];
    o[5] = i[7] ^ i[5] ^ i[4] ^ i[1];
    o[4] = i[6] ^ i[5] ^ i[4] ^ i[3] ^ i[2] ^ i[1];
    o[3] = i[6] ^ i[1];
    o[2] = i[7] ^ i[6] ^ i[5] ^ i[3] ^ i[2] ^ i[0];
    o[1] = i[7] ^ i[6] ^ i[5] ^ i[3] ^ i[1] ^ i[0];
    o[0] = i[4] ^ i[1];
    return o;
  endfunction

  always_comb begin
    map_data = '0;
    lane_in  = '0;
    lane_out = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_in = in_data[8*k +: 8];
      if (in_mode) begin
        for (int r = 0; r < 8; r++) begin
          lane_out[r] = ^(act_row[r] & lane_in);
        end
      end else begin
        lane_out = inv_map(lane_in);
      end
      map_data[8*k +: 8] = lane_out ^ act_const;
    end
  end

  // Mode-1 input is also held off during COMMIT so it always sees the new matrix.
  assign mode1_block = (state == DRAIN) || (state == COMMIT);
  assign out_valid   = st_valid[PIPE-1];
  assign out_data    = st_data[PIPE-1];
  assign stall       = out_valid & ~out_ready;
  assign in_ready    = ~stall & ~(in_mode & mode1_block);
  assign accept      = in_valid & in_ready;
  assign mode1_busy  = |(st_valid & st_mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      st_mode  <= '0;
      for (int s = 0; s < PIPE; s++) begin
        st_data[s] <= '0;
      end
    end else if (!stall) begin
      st_valid[0] <= accept;
      st_mode[0]  <= in_mode;
      if (accept) begin
        st_data[0] <= map_data;
      end
      for (int s = 1; s < PIPE; s++) begin
        st_valid[s] <= st_valid[s-1];
        st_mode[s]  <= st_mode[s-1];
        st_data[s]  <= st_data[s-1];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    row_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_start) state_nxt = LOAD;
      end
      LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          row_we = 1'b1;
          if (wcnt == LAST_WORD) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!mode1_busy) state_nxt = COMMIT;
      end
      COMMIT: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cfg_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wcnt  <= '0;
      for (int r = 0; r < 8; r++) begin
        act_row[r] <= 8'(1 << r);
        shd_row[r] <= 8'(1 << r);
      end
    end else begin
      state <= state_nxt;
      if (state == IDLE && cfg_start) begin
        wcnt <= '0;
      end else if (row_we) begin
        wcnt <= wcnt + 4'd1;
      end
      for (int r = 0; r < 8; r++) begin
        if (row_we && wcnt == 4'(r) + ROW_OFS) shd_row[r] <= cfg_row;
        if (state == COMMIT) act_row[r] <= shd_row[r];
      end
    end
  end

`ifdef AFFINE_CONST_EN
  logic [7:0] shd_const;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_const <= 8'h00;
      act_const <= 8'h00;
    end else begin
      if (row_we && wcnt == 4'd0) shd_const <= cfg_row;
      if (state == COMMIT) act_const <= shd_const;
    end
  end
`else
  assign act_const = 8'h00;
`endif

endmodule
